// File: rtl/svf_ctrl_pkg.sv
// svf_ctrl_pkg: shared FSM state type, accumulator width and saturation helper for the SVF sequencer
package svf_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, FILTER, MIX} state_t;
  localparam int ACC_W = 10;
  function automatic logic signed [7:0] sat8(input logic signed [15:0] v);
    return v > 16'sd127 ? 8'sh7f : v < -16'sd128 ? 8'sh80 : v[7:0];
  endfunction
endpackage

// File: rtl/svf_fc_slew.sv
// svf_fc_slew: cutoff coefficient register that moves at most FC_STEP toward its target per update
module svf_fc_slew #(
  parameter int FC_STEP = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] target,
  input  logic        update,
  output logic [10:0] fc_cur
);
  logic [10:0] up_gap, dn_gap, fc_next;
  always_comb begin
    up_gap = target - fc_cur;
    dn_gap = fc_cur - target;
    fc_next = target >= fc_cur ? (up_gap <= 11'(FC_STEP) ? target : fc_cur + 11'(FC_STEP))
                               : (dn_gap <= 11'(FC_STEP) ? target : fc_cur - 11'(FC_STEP));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) fc_cur <= '0;
    else if (update) fc_cur <= fc_next;
endmodule

// File: rtl/svf_filter_sequencer.sv
// svf_filter_sequencer: per-sample voice summing, one shared SVF step, mode mix and master volume
module svf_filter_sequencer
  import svf_ctrl_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int FC_STEP    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_tick,
  input  logic [8*NUM_VOICES-1:0] voice_in,
  input  logic [NUM_VOICES-1:0]   filt_route,
  input  logic [2:0]              mode,
  input  logic [10:0]             fc_target,
  input  logic [1:0]              res,
  input  logic [3:0]              volume,
  output logic [7:0]              svf_in,
  output logic                    svf_sample_valid,
  output logic [10:0]             svf_alpha1,
  output logic [1:0]              svf_alpha2,
  input  logic [7:0]              svf_hp,
  input  logic [7:0]              svf_bp,
  input  logic [7:0]              svf_lp,
  output logic [7:0]              out_sample,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);
  localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  state_t state, state_d;
  logic [8*NUM_VOICES-1:0] voices_q;
  logic [NUM_VOICES-1:0] route_q;
  logic [2:0] mode_q;
  logic [3:0] vol_q;
  logic [IW-1:0] idx;
  logic last;
  logic signed [ACC_W-1:0] filt_acc, dir_acc, voice_ext, filt_next, dir_next, fsum;
  logic signed [7:0] hp_q, bp_q, lp_q;
  logic signed [10:0] total;
  logic signed [15:0] prod;
  assign busy = state != IDLE;
  assign svf_sample_valid = state == FILTER;
  always_comb begin
    last = idx == IW'(NUM_VOICES - 1);
    voice_ext = ACC_W'($signed(voices_q[8*idx +: 8]));
    filt_next = filt_acc + (route_q[idx] ? voice_ext : '0);
    dir_next = dir_acc + (route_q[idx] ? '0 : voice_ext);
    fsum = (mode_q[0] ? ACC_W'(lp_q) : '0) + (mode_q[1] ? ACC_W'(bp_q) : '0) + (mode_q[2] ? ACC_W'(hp_q) : '0);
    total = 11'(fsum) + 11'(dir_acc >>> 1);
    prod = 16'(total) * $signed({12'b0, vol_q});
    state_d = state == IDLE   ? (sample_tick ? ACCUM : IDLE) :
              state == ACCUM  ? (last ? FILTER : ACCUM) :
              state == FILTER ? MIX : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      voices_q <= '0;
      route_q <= '0;
      mode_q <= '0;
      vol_q <= '0;
      svf_alpha2 <= '0;
      idx <= '0;
      filt_acc <= '0;
      dir_acc <= '0;
      svf_in <= '0;
      hp_q <= '0;
      bp_q <= '0;
      lp_q <= '0;
      out_sample <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_d;
      out_valid <= state == MIX;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && sample_tick) begin
        voices_q <= voice_in;
        route_q <= filt_route;
        mode_q <= mode;
        vol_q <= volume;
        svf_alpha2 <= res;
        filt_acc <= '0;
        dir_acc <= '0;
        idx <= '0;
      end
      if (state == ACCUM) begin
        filt_acc <= filt_next;
        dir_acc <= dir_next;
        idx <= idx + 1'b1;
        // register the final filter-bus value so it is stable for the whole FILTER cycle
        if (last) svf_in <= sat8(16'(filt_next >>> 1));
      end
      if (state == FILTER) begin
        hp_q <= svf_hp;
        bp_q <= svf_bp;
        lp_q <= svf_lp;
      end
      if (state == MIX) out_sample <= sat8(prod >>> 4);
    end
  end
  svf_fc_slew #(.FC_STEP(FC_STEP)) u_slew (
    .clk(clk),
    .rst(rst),
    .target(fc_target),
    .update(state == FILTER),
    .fc_cur(svf_alpha1)
  );
endmodule

// File: doc/svf_filter_sequencer.md
Name: svf_filter_sequencer

Overview:
- Per-sample controller for the shared 8-bit Chamberlin SVF core. On each sample tick it latches the voice samples and sums them into a filtered bus and a direct bus, one voice per cycle.
- It then clocks the SVF once and selects and mixes the HP/BP/LP outputs per mode bits, adds the direct bus, and applies master volume.
- It also slew-limits the cutoff coefficient to suppress zipper noise.
- Sits between the voice generators and the output DAC/PWM stage.

Parameters:
- NUM_VOICES, 3, number of voice inputs; the ACCUM phase lasts NUM_VOICES cycles.
- FC_STEP, 32, maximum change of the cutoff register per processed sample (11-bit units).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sample_tick  in  1  one-cycle strobe requesting one output sample
- voice_in  in  8*NUM_VOICES  packed signed 8-bit voice samples; voice k = [8k+7:8k]
- filt_route  in  NUM_VOICES  1 = voice k goes to the filter bus, 0 = direct bus
- mode  in  3  [0]=LP, [1]=BP, [2]=HP enables
- fc_target  in  11  requested cutoff coefficient
- res  in  2  damping coefficient
- volume  in  4  master volume, gain volume/16
- svf_in  out  8  signed filter input to the SVF
- svf_sample_valid  out  1  SVF state-advance strobe
- svf_alpha1  out  11  cutoff coefficient to the SVF
- svf_alpha2  out  2  damping coefficient to the SVF
- svf_hp, svf_bp, svf_lp  in  8 each  signed combinational SVF outputs
- out_sample  out  8  signed mixed output
- out_valid  out  1  one-cycle strobe; out_sample is new
- busy  out  1  high when the FSM is not IDLE
- overrun  out  1  sticky; a tick arrived while busy

Behaviour:
- Reset (async): FSM=IDLE. All registers 0, including fc_cur, accumulators, captured SVF outputs, out_sample, out_valid, busy, overrun, and the latched res/route/mode/volume. Reset mid-operation aborts the sample: no out_valid and no further svf_sample_valid.
- FSM states: IDLE, ACCUM, FILTER, MIX.
- IDLE:
  - On sample_tick, latch voice_in, filt_route, mode, res and volume.
  - Clear both 10-bit signed accumulators (filt_acc, dir_acc) and the voice index.
  - Go to ACCUM.
- ACCUM:
  - Each cycle, sign-extend latched voice[idx] and add it to filt_acc if route[idx], otherwise to dir_acc.
  - Increment idx. After idx = NUM_VOICES-1, go to FILTER.
- FILTER (exactly one cycle):
  - svf_sample_valid=1.
  - svf_in = sat8(filt_acc >>> 1). svf_in is held at that value at all times and is registered.
  - Capture svf_hp/bp/lp into registers in this same cycle; they are valid combinationally from the pre-update SVF state.
  - At the clock edge ending this cycle, update fc_cur:
    - if |fc_target - fc_cur| <= FC_STEP, then fc_cur = fc_target;
    - else fc_cur moves FC_STEP toward fc_target.
- MIX (one cycle):
  - fsum = sum of the captured outputs enabled by mode (10-bit signed).
  - total = fsum + (dir_acc >>> 1), 11-bit signed.
  - prod = total * volume, unsigned volume zero-extended, 16-bit signed.
  - out_sample <= sat8(prod >>> 4). out_valid <= 1 for the next cycle only. Return to IDLE.
- mode=000 gives filter contribution 0; the SVF is still clocked.
- Latency: tick high in cycle 0 → svf_sample_valid in cycle NUM_VOICES+1 → out_valid in cycle NUM_VOICES+3 (cycle 6 at default). out_sample holds until the next update.
- svf_alpha1 = fc_cur; svf_alpha2 = latched res. Both are registered and stable outside reset.
- sample_tick while busy (including the IDLE→ACCUM cycle):
  - The tick is ignored and overrun is set.
  - A tick in the same cycle that out_valid is high is accepted; the FSM is back in IDLE by then.
- sat8: clamp to [-128, 127]. All shifts are arithmetic.

Decomposition:
- Package svf_ctrl_pkg: FSM state enum, accumulator width constant (10), sat8 function.
- One sub-module, svf_fc_slew: holds fc_cur, with inputs target and update strobe, and implements the step/clamp rule.

Test Plan:
1. Reset, voices 0, mode=LP, volume 15, one tick at cycle 0 → svf_sample_valid only in cycle 4, out_valid only in cycle 6, out_sample=0, busy cycles 1–5.
2. filt_route=000, voices {40,20,-10}, volume 15 → dir_acc=50, 25*15=375>>>4=23 → out_sample=23. Same with volume 0 → out_sample=0.
3. Saturation on the filter bus: filt_route=111, voices 127 each → svf_in=127 (190 clamped). Saturation on the direct bus: filt_route=000, voices 127 each → 190*15>>>4=178 → out_sample=127. Voices -128 each, route 000 → -192*15>>>4=-180 → out_sample=-128.
4. Slew: fc_cur=0, fc_target=2016, FC_STEP=32, repeated ticks → svf_alpha1 = 0, 32, 64, … after each FILTER; equals 2016 after 63 samples and holds. Target 10 from 0 → 10 after one sample.
5. Overrun: ticks at cycles 0 and 2 → one out_valid (cycle 6), overrun=1. A tick at cycle 6 is accepted → out_valid at cycle 12.
6. rst asserted in cycle 3 of a sample → outputs 0 immediately, no svf_sample_valid, no out_valid, FSM IDLE. The next tick after reset release processes normally.
